// File: rtl/ram_sdp_be_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enable RAM.
// lane_merge works at a fixed maximum width; callers cast to and from their own word width.
package ram_pkg;

   localparam int MAX_DWL = 256;
   localparam int MAX_NB  = MAX_DWL / 8;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_e;

   function automatic int nb_of(input int dwl);
      return dwl / 8;
   endfunction

   function automatic logic [MAX_DWL-1:0] lane_merge(
      input logic [MAX_DWL-1:0] oldWord,
      input logic [MAX_DWL-1:0] newWord,
      input logic [MAX_NB-1:0]  be
   );
      logic [MAX_DWL-1:0] res;
      res = oldWord;
      for (int b = 0; b < MAX_NB; b++) begin
         if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// Access port of ram_sdp_be: write channel, read channel, clear request and status.
interface ram_sdp_be_if #(
   parameter int DWL = 32,
   parameter int AWL = 8
);
   import ram_pkg::*;

   localparam int NB = nb_of(DWL);

   logic           clr;
   logic           busy;
   logic           wen;
   logic [AWL-1:0] waddr;
   logic [NB-1:0]  wbe;
   logic [DWL-1:0] data_in;
   logic           ren;
   logic [AWL-1:0] raddr;
   logic           rvalid;
   logic [DWL-1:0] data_out;

   modport master (
      output clr, wen, waddr, wbe, data_in, ren, raddr,
      input  busy, rvalid, data_out
   );

   modport slave (
      input  clr, wen, waddr, wbe, data_in, ren, raddr,
      output busy, rvalid, data_out
   );

endinterface

// File: rtl/ram_sdp_be_clear_fsm.sv
// Clear engine: sweeps every address writing zero after reset or on a clr pulse,
// and reports busy for the whole sweep.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int AWL = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_clr,
   output logic           o_busy,
   output logic           o_clear_we,
   output logic [AWL-1:0] o_clear_addr
);

   localparam logic [0:0]     S_CLEAR = CLEAR;
   localparam logic [0:0]     S_READY = READY;
   localparam logic [AWL-1:0] LAST    = '1;

   logic [0:0]     r_state;
   logic [AWL-1:0] r_cnt;

   // The counter naturally returns to zero after the last word, ready for the next sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_cnt <= r_cnt + AWL'(1);
               if (r_cnt == LAST) r_state <= S_READY;
            end
            default: begin
               if (i_clr) begin
                  r_state <= S_CLEAR;
                  r_cnt   <= '0;
               end
            end
         endcase
      end
   end

   assign o_busy       = (r_state == S_CLEAR);
   assign o_clear_we   = o_busy;
   assign o_clear_addr = r_cnt;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-lane writes, 1- or 2-cycle registered reads,
// selectable write-first/read-first collision behaviour and a hardware clear sweep.
module ram_sdp_be
   import ram_pkg::*;
#(
   parameter int DWL         = 32,
   parameter int AWL         = 8,
   parameter int RD_LAT      = 1,
   parameter int WRITE_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   ram_sdp_be_if.slave  bus
);

   localparam int NB = nb_of(DWL);

   if (DWL % 8 != 0 || NB * 8 != DWL || DWL > MAX_DWL) begin : g_badDwl
      $error("ram_sdp_be: DWL must be a multiple of 8 and no larger than MAX_DWL");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_badLat
      $error("ram_sdp_be: RD_LAT must be 1 or 2");
   end

   logic [DWL-1:0] r_mem [2**AWL];

   logic           w_busy;
   logic           w_clearWe;
   logic [AWL-1:0] w_clearAddr;
   logic           w_accept;
   logic           w_wrAcc;
   logic           w_rdAcc;
   logic           w_collide;
   logic [DWL-1:0] w_wrOld;
   logic [DWL-1:0] w_wrMerged;
   logic [DWL-1:0] w_rdOld;
   logic [DWL-1:0] w_rdWord;

   ram_clear_fsm #(.AWL(AWL)) u_clearFsm (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (bus.clr),
      .o_busy       (w_busy),
      .o_clear_we   (w_clearWe),
      .o_clear_addr (w_clearAddr)
   );

   assign bus.busy = w_busy;

   // A clr request in READY takes priority and drops any access in the same cycle.
   assign w_accept   = !w_busy && !bus.clr;
   assign w_wrAcc    = w_accept && bus.wen;
   assign w_rdAcc    = w_accept && bus.ren;
   assign w_collide  = w_wrAcc && (bus.waddr == bus.raddr);

   assign w_wrOld    = r_mem[bus.waddr];
   assign w_wrMerged = DWL'(lane_merge(MAX_DWL'(w_wrOld), MAX_DWL'(bus.data_in), MAX_NB'(bus.wbe)));
   assign w_rdOld    = r_mem[bus.raddr];
   assign w_rdWord   = ((WRITE_FIRST != 0) && w_collide) ? w_wrMerged : w_rdOld;

   always_ff @(posedge clk) begin
      if (w_clearWe) begin
         r_mem[w_clearAddr] <= '0;
      end else if (w_wrAcc) begin
         r_mem[bus.waddr] <= w_wrMerged;
      end
   end

   logic           r_v1;
   logic [DWL-1:0] r_d1;

   // Data registers only load on a valid read so data_out holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
      end else begin
         r_v1 <= w_rdAcc;
         if (w_rdAcc) r_d1 <= w_rdWord;
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic           r_v2;
      logic [DWL-1:0] r_d2;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v2 <= 1'b0;
            r_d2 <= '0;
         end else begin
            r_v2 <= r_v1;
            if (r_v1) r_d2 <= r_d1;
         end
      end

      assign bus.rvalid   = r_v2;
      assign bus.data_out = r_d2;
   end else begin : g_lat1
      assign bus.rvalid   = r_v1;
      assign bus.data_out = r_d1;
   end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (RD_LAT=1 write-first, RD_LAT=2 read-first)
// driven identically and compared each cycle against a word-level reference model.
module tb_ram_sdp_be;

   localparam int DWL   = 32;
   localparam int AWL   = 4;
   localparam int DEPTH = 16;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_sdp_be_if #(.DWL(DWL), .AWL(AWL)) ifA ();
   ram_sdp_be_if #(.DWL(DWL), .AWL(AWL)) ifB ();

   ram_sdp_be #(.DWL(DWL), .AWL(AWL), .RD_LAT(1), .WRITE_FIRST(1)) dutA (
      .clk (clk), .rst (rst), .bus (ifA.slave)
   );
   ram_sdp_be #(.DWL(DWL), .AWL(AWL), .RD_LAT(2), .WRITE_FIRST(0)) dutB (
      .clk (clk), .rst (rst), .bus (ifB.slave)
   );

   logic [31:0] modelMem [DEPTH];
   rd_t         qA[$];
   rd_t         qB[$];
   int          busyLeft;
   int          cyc;
   int          checks;
   int          errors;
   logic        expBusy  [2];
   logic        expValid [2];
   logic [31:0] expData  [2];
   logic [31:0] lastData [2];
   logic        obsBusy  [2];
   logic        obsValid [2];
   logic [31:0] obsData  [2];

   // Word-level byte-lane merge of the reference model
   function automatic logic [31:0] merge(input logic [31:0] oldW, input logic [31:0] newW,
                                         input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         m = m | ((be[b] ? newW : oldW) & (32'hFF << (8 * b)));
      end
      return m;
   endfunction

   task automatic modelReset();
      busyLeft = DEPTH;
      qA.delete();
      qB.delete();
      lastData[0] = '0;
      lastData[1] = '0;
   endtask

   task automatic drive(input logic iClr, input logic iWen, input logic [3:0] iWaddr,
                        input logic [3:0] iWbe, input logic [31:0] iData,
                        input logic iRen, input logic [3:0] iRaddr);
      ifA.clr = iClr; ifA.wen = iWen; ifA.waddr = iWaddr; ifA.wbe = iWbe;
      ifA.data_in = iData; ifA.ren = iRen; ifA.raddr = iRaddr;
      ifB.clr = iClr; ifB.wen = iWen; ifB.waddr = iWaddr; ifB.wbe = iWbe;
      ifB.data_in = iData; ifB.ren = iRen; ifB.raddr = iRaddr;
   endtask

   // One clock: drive inputs, advance the model, sample outputs 1ns after the edge
   task automatic step(input logic iClr, input logic iWen, input logic [3:0] iWaddr,
                       input logic [3:0] iWbe, input logic [31:0] iData,
                       input logic iRen, input logic [3:0] iRaddr);
      logic        acc;
      logic [31:0] oldW;
      logic [31:0] newW;
      rd_t         item;
      drive(iClr, iWen, iWaddr, iWbe, iData, iRen, iRaddr);
      acc  = (busyLeft == 0) && !iClr;
      oldW = modelMem[iRaddr];
      newW = merge(modelMem[iWaddr], iData, iWbe);
      if (acc && iRen) begin
         item.due  = cyc + 1;
         item.data = (iWen && iWaddr == iRaddr) ? newW : oldW;
         qA.push_back(item);
         item.due  = cyc + 2;
         item.data = oldW;
         qB.push_back(item);
      end
      if (acc && iWen) modelMem[iWaddr] = newW;
      if (busyLeft > 0) begin
         busyLeft--;
      end else if (iClr) begin
         busyLeft = DEPTH;
         for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      end
      @(posedge clk);
      cyc++;
      #1;
      expBusy[0] = (busyLeft > 0);
      expBusy[1] = (busyLeft > 0);
      expValid[0] = 1'b0;
      if (qA.size() > 0 && qA[0].due == cyc) begin
         expValid[0] = 1'b1;
         lastData[0] = qA[0].data;
         void'(qA.pop_front());
      end
      expValid[1] = 1'b0;
      if (qB.size() > 0 && qB[0].due == cyc) begin
         expValid[1] = 1'b1;
         lastData[1] = qB[0].data;
         void'(qB.pop_front());
      end
      expData[0] = lastData[0];
      expData[1] = lastData[1];
      obsBusy[0] = ifA.busy; obsValid[0] = ifA.rvalid; obsData[0] = ifA.data_out;
      obsBusy[1] = ifB.busy; obsValid[1] = ifB.rvalid; obsData[1] = ifB.data_out;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
   endtask

   // Random accesses while the sweep runs; all of them must be ignored
   task automatic busyPoke();
      step(1'b0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), $urandom,
           1'b1, 4'($urandom_range(15)));
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
      rst = 1'b1;
      #12;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ((d == 0 ? {ifA.busy, ifA.rvalid, ifA.data_out} : {ifB.busy, ifB.rvalid, ifB.data_out})
             !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_state dut%0d: busy,rvalid,data_out = %b,%b,%h expected 1,0,00000000",
                     d, d == 0 ? ifA.busy : ifB.busy, d == 0 ? ifA.rvalid : ifB.rvalid,
                     d == 0 ? ifA.data_out : ifB.data_out);
         end
      end
      rst = 1'b0;
      modelReset();
      begin
         int n;
         n = 0;
         while (ifA.busy && n < 40) begin
            n++;
            busyPoke();
            for (int d = 0; d < 2; d++) begin
               checks++;
               if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
                  errors++;
                  $display("[TB] FAIL reset_sweep dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                           d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
               end
            end
         end
         checks++;
         if (n !== 16) begin
            errors++;
            $display("[TB] FAIL reset_busy_len: busy cycles %0d expected 16", n);
         end
      end
   endtask

   task automatic test_read_zero();
      for (int k = 0; k < DEPTH + 2; k++) begin
         if (k < DEPTH) step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(k));
         else idle();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
               errors++;
               $display("[TB] FAIL read_zero dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                        d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
            end
         end
         if (k < DEPTH) begin
            checks++;
            if ({obsValid[0], obsData[0]} !== {1'b1, 32'h0}) begin
               errors++;
               $display("[TB] FAIL read_zero_a addr %0d: valid,data = %b,%h expected 1,00000000",
                        k, obsValid[0], obsData[0]);
            end
         end
      end
   endtask

   task automatic test_byte_lanes();
      step(1'b0, 1'b1, 4'd3, 4'b1111, 32'hAABBCCDD, 1'b0, 4'd0);
      step(1'b0, 1'b1, 4'd3, 4'b0101, 32'h11223344, 1'b0, 4'd0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
      checks++;
      if ({obsValid[0], obsData[0]} !== {1'b1, 32'hAA22CC44}) begin
         errors++;
         $display("[TB] FAIL byte_lanes_a: valid,data = %b,%h expected 1,aa22cc44", obsValid[0], obsData[0]);
      end
      idle();
      checks++;
      if ({obsValid[1], obsData[1]} !== {1'b1, 32'hAA22CC44}) begin
         errors++;
         $display("[TB] FAIL byte_lanes_b: valid,data = %b,%h expected 1,aa22cc44", obsValid[1], obsData[1]);
      end
   endtask

   task automatic test_collision();
      step(1'b0, 1'b1, 4'd5, 4'b0011, 32'hDEADBEEF, 1'b1, 4'd5);
      checks++;
      if ({obsValid[0], obsData[0]} !== {1'b1, 32'h0000BEEF}) begin
         errors++;
         $display("[TB] FAIL collide_write_first: valid,data = %b,%h expected 1,0000beef", obsValid[0], obsData[0]);
      end
      idle();
      checks++;
      if ({obsValid[1], obsData[1]} !== {1'b1, 32'h00000000}) begin
         errors++;
         $display("[TB] FAIL collide_read_first: valid,data = %b,%h expected 1,00000000", obsValid[1], obsData[1]);
      end
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
      checks++;
      if ({obsValid[0], obsData[0]} !== {1'b1, 32'h0000BEEF}) begin
         errors++;
         $display("[TB] FAIL collide_after_a: valid,data = %b,%h expected 1,0000beef", obsValid[0], obsData[0]);
      end
      idle();
      checks++;
      if ({obsValid[1], obsData[1]} !== {1'b1, 32'h0000BEEF}) begin
         errors++;
         $display("[TB] FAIL collide_after_b: valid,data = %b,%h expected 1,0000beef", obsValid[1], obsData[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] dat [3];
      logic [4:0]  validB;
      for (int i = 0; i < 3; i++) begin
         dat[i] = $urandom;
         step(1'b0, 1'b1, 4'(i), 4'b1111, dat[i], 1'b0, 4'd0);
      end
      for (int k = 0; k < 5; k++) begin
         if (k < 3) step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(k));
         else idle();
         validB[k] = obsValid[1];
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
               errors++;
               $display("[TB] FAIL back_to_back dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                        d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
            end
         end
         if (k >= 1 && k <= 3) begin
            checks++;
            if (obsData[1] !== dat[k-1]) begin
               errors++;
               $display("[TB] FAIL back_to_back_data_b slot %0d: data %h expected %h", k, obsData[1], dat[k-1]);
            end
         end
      end
      checks++;
      if (validB !== 5'b01110) begin
         errors++;
         $display("[TB] FAIL back_to_back_valid_b: rvalid pattern %b expected 01110", validB);
      end
   endtask

   task automatic test_clear_request();
      int n;
      step(1'b0, 1'b1, 4'd7, 4'b1111, 32'h12345678, 1'b0, 4'd0);
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7);
      step(1'b1, 1'b1, 4'd8, 4'b1111, $urandom, 1'b0, 4'd0);
      n = 0;
      while (ifA.busy && n < 40) begin
         n++;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
               errors++;
               $display("[TB] FAIL clear_sweep dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                        d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
            end
         end
         busyPoke();
      end
      checks++;
      if (n !== 16) begin
         errors++;
         $display("[TB] FAIL clear_busy_len: busy cycles %0d expected 16", n);
      end
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7);
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd8);
      checks++;
      if ({obsValid[0], obsData[0], obsValid[1], obsData[1]} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL clear_zeroed: A valid,data = %b,%h  B valid,data = %b,%h expected 1,00000000 both",
                  obsValid[0], obsData[0], obsValid[1], obsData[1]);
      end
      idle();
      checks++;
      if ({obsValid[1], obsData[1]} !== {1'b1, 32'h0}) begin
         errors++;
         $display("[TB] FAIL clear_dropped_write_b: valid,data = %b,%h expected 1,00000000", obsValid[1], obsData[1]);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
      step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1);
      for (int k = 0; k < 9; k++) busyPoke();
      rst = 1'b1;
      #2;
      checks++;
      if ({ifA.busy, ifA.rvalid, ifB.busy, ifB.rvalid} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL mid_sweep_reset: busyA,rvalidA,busyB,rvalidB = %b%b%b%b expected 1010",
                  ifA.busy, ifA.rvalid, ifB.busy, ifB.rvalid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      n = 0;
      while (ifA.busy && n < 40) begin
         n++;
         busyPoke();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
               errors++;
               $display("[TB] FAIL mid_sweep dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                        d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
            end
         end
      end
      checks++;
      if (n !== 16) begin
         errors++;
         $display("[TB] FAIL mid_sweep_busy_len: busy cycles %0d expected 16", n);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(49) == 0, 1'($urandom), 4'($urandom_range(15)), 4'($urandom_range(15)),
              $urandom, 1'($urandom), 4'($urandom_range(15)));
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({obsBusy[d], obsValid[d], obsData[d]} !== {expBusy[d], expValid[d], expData[d]}) begin
               errors++;
               $display("[TB] FAIL random dut%0d cyc %0d: busy,valid,data = %b,%b,%h expected %b,%b,%h",
                        d, cyc, obsBusy[d], obsValid[d], obsData[d], expBusy[d], expValid[d], expData[d]);
            end
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      modelReset();
      test_reset();
      test_read_zero();
      test_byte_lanes();
      test_collision();
      test_back_to_back();
      test_clear_request();
      test_reset_mid_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
Parametrised simple-dual-port RAM with byte-lane write enables, registered reads of configurable latency and write-first/read-first collision handling. It adds a hardware clear engine that zeroes every word after reset or on request. It is the general-purpose storage block for datapaths that need independent read and write addresses. It replaces the 256-deep, single-address, async-read distributed RAM.

Parameters:
DWL, 32, data word width in bits; must be a multiple of 8 (elaboration error otherwise); NB = DWL/8 byte lanes
AWL, 8, address width; DEPTH = 2**AWL words
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
WRITE_FIRST, 1, 1 = a same-address read returns newly written lanes; 0 = it returns old data

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  single-cycle pulse; requests zeroing of the whole array
busy  output  1  high while the clear engine runs; the port ignores accesses while high
wen  input  1  write enable
waddr  input  AWL  write address
wbe  input  NB  byte-lane write enables; lane b is data_in[8b+7:8b]
data_in  input  DWL  write data
ren  input  1  read enable
raddr  input  AWL  read address
rvalid  output  1  pulses RD_LAT cycles after an accepted read
data_out  output  DWL  read data; holds its last value between reads

Behaviour:
- Reset (asynchronous): state=CLEAR, clear counter=0, busy=1, rvalid=0, data_out=0, all read pipeline registers and valid bits=0. Array contents are not reset directly; the clear sweep zeroes them.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle, mem[cnt] <= 0 and cnt increments.
  - When cnt==DEPTH-1 is written, next state is READY. A sweep takes exactly DEPTH cycles.
  - busy falls on the edge that enters READY.
- CLEAR, accesses: wen and ren are ignored with no array change and no rvalid. A clr pulse during CLEAR is ignored; no restart.
- READY with clr=1: next state is CLEAR with cnt=0 and busy=1 next cycle. A wen or ren in the same cycle is dropped. Reads already in flight still complete.
- Write (READY, wen=1, clr=0): for each b with wbe[b]=1, mem[waddr] lane b <= data_in lane b. Lanes with wbe[b]=0 are unchanged. wbe=0 is a no-op.
- Read (READY, ren=1, clr=0):
  - RD_LAT=1: data_out and rvalid update at the next edge.
  - RD_LAT=2: one extra register stage is added.
  - Back-to-back reads give one result per cycle.
  - When rvalid=0, data_out holds its value.
- Collision (wen, ren and waddr==raddr in the same accepted cycle):
  - WRITE_FIRST=1: result = enabled lanes from data_in, other lanes from the old word.
  - WRITE_FIRST=0: result = the old word.
  - The array always takes the write.
- Address wrap: none; addresses are exactly AWL bits, and the sweep ends at DEPTH-1 with no rollover into READY state logic.
- Reset mid-sweep or mid-read: the sweep restarts from 0 and in-flight reads are discarded (rvalid=0).

Decomposition:
- Package ram_pkg holds:
  - the state enum typedef (CLEAR, READY)
  - a function lane_merge(old, new, be) for byte-lane merging, shared by the write and collision paths
  - NB derivation helper as a localparam function
- One sub-module, ram_clear_fsm, contains the state register, the AWL-bit counter and busy. It drives the array clear write port (clear_we, clear_addr).
- The top level contains the array, the port muxing and the read pipeline.

Test Plan:
- DWL=32, AWL=4: deassert rst and count cycles -> busy high for exactly 16 cycles; reads afterwards at all addresses return 0x00000000 with rvalid one cycle later.
- Write 0xAABBCCDD to addr 3 with wbe=4'b1111, then 0x11223344 with wbe=4'b0101, read addr 3 -> data_out=0xAA22CC44.
- WRITE_FIRST=1: addr 5 holds 0x0; same-cycle wen/ren at addr 5 with data 0xDEADBEEF and wbe=4'b0011 -> data_out=0x0000BEEF; with WRITE_FIRST=0 -> 0x00000000; a later read returns 0x0000BEEF in both cases.
- RD_LAT=2: reads of addr 0,1,2 on consecutive cycles -> rvalid high on cycles 2,3,4 after the first ren, with matching data.
- Fill addr 7 with 0x12345678, pulse clr with wen=1 at addr 8 in the same cycle -> busy for 16 cycles, write dropped; then addr 7 and addr 8 both read 0.
- Assert rst at sweep count 9 -> busy stays high and the full 16-cycle sweep restarts from 0 after release; rvalid stays 0 throughout.
